uart_rx_ctrl: RTL

//  Receive-side UART engine, the counterpart of the TX FSM/serializer path.
//  - Oversamples rx_in at prescale x bit rate and detects the start bit.
//  - Majority-votes each bit, deserializes LSB first, checks optional parity and the stop bit.
//  - Delivers a parallel byte with a 1-cycle valid strobe to the system control block.

---
 rtl/uart_rx_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling UART receiver. It detects the start bit and
// majority-votes three mid-bit samples for each bit. Data is shifted in LSB
// first, then optional parity and the stop bit are checked. The result is one
// registered strobe set per frame.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  // edge counter spans 0..31, the largest supported oversampling ratio
  localparam int CW = 5;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [CW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [2:0]            smp;
  logic [1:0]            psel_q;   // 0: x8, 1: x16, 2: x32
  logic                  pe_q;
  logic                  pt_q;
  logic                  par_bad;

  logic [1:0]            psel_d;
  logic [CW-1:0]         p_last;
  logic [CW-1:0]         p_mid;
  logic                  last_edge;
  logic                  vote;

  // decode the live prescale input; anything unsupported runs at x8
  always_comb begin
    psel_d = 2'd0;
    if (prescale == PRESC_W'(16))      psel_d = 2'd1;
    else if (prescale == PRESC_W'(32)) psel_d = 2'd2;
  end

  // bit-period constants for the ratio latched at start detection
  always_comb begin
    p_last = CW'(7);
    p_mid  = CW'(4);
    case (psel_q)
      2'd1:    begin p_last = CW'(15); p_mid = CW'(8);  end
      2'd2:    begin p_last = CW'(31); p_mid = CW'(16); end
      default: begin p_last = CW'(7);  p_mid = CW'(4);  end
    endcase
  end

  assign last_edge = (edge_cnt == p_last);
  assign vote      = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

  // receive FSM with timing counters, mid-bit sampling and registered strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      smp        <= '0;
      psel_q     <= '0;
      pe_q       <= 1'b0;
      pt_q       <= 1'b0;
      par_bad    <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      if (state != IDLE) begin
        if (edge_cnt == p_mid - CW'(1)) smp[0] <= rx_in;
        if (edge_cnt == p_mid)          smp[1] <= rx_in;
        if (edge_cnt == p_mid + CW'(1)) smp[2] <= rx_in;
        edge_cnt <= last_edge ? '0 : edge_cnt + CW'(1);
      end

      case (state)
        IDLE: begin
          edge_cnt <= '0;
          if (!rx_in) begin
            // detection cycle is edge 0 of the start bit
            state    <= START;
            edge_cnt <= CW'(1);
            psel_q   <= psel_d;
            pe_q     <= par_en;
            pt_q     <= par_typ;
            par_bad  <= 1'b0;
          end
        end
        START: begin
          if (last_edge) begin
            bit_cnt <= '0;
            state   <= vote ? IDLE : DATA;
          end
        end
        DATA: begin
          if (last_edge) begin
            shift_reg <= {vote, shift_reg[DATA_WIDTH-1:1]};
            if (bit_cnt == BW'(DATA_WIDTH - 1)) state <= pe_q ? PARITY : STOP;
            else                                 bit_cnt <= bit_cnt + BW'(1);
          end
        end
        PARITY: begin
          if (last_edge) begin
            par_bad <= (vote != (^shift_reg ^ pt_q));
            state   <= STOP;
          end
        end
        STOP: begin
          if (last_edge) begin
            state <= IDLE;
            if (!par_bad && vote) begin
              data_valid <= 1'b1;
              p_data     <= shift_reg;
            end else begin
              par_err <= par_bad;
              stp_err <= ~vote;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
